// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-stated data memory slave with byte/half/word lanes
// Four-phase req/ready handshake; ready and err are asserted one edge after DONE is entered.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_type,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        mem_w_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  type_q;
  logic [31:0] rdata_q;
  logic        ready_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic             bad;
  logic [31:0]      word_rd;
  logic [15:0]      half_rd;
  logic [7:0]       byte_rd;
  logic [31:0]      rdata_d;
  logic [3:0]       be;
  logic [31:0]      st_data;

  assign idx     = addr_q[IDX_W+1:2];
  assign word_rd = mem[idx];
  assign half_rd = addr_q[1] ? word_rd[31:16] : word_rd[15:0];
  assign byte_rd = word_rd[{addr_q[1:0], 3'b000} +: 8];

  always_comb begin
    bad = 1'b0;
    case (type_q)
      3'd0:       bad = (addr_q[1:0] != 2'b00);
      3'd1, 3'd2: bad = addr_q[0];
      3'd3, 3'd4: bad = 1'b0;
      default:    bad = 1'b1;
    endcase
    if ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS)) bad = 1'b1;
  end

  // Errored loads return zero rather than whatever the truncated index hits.
  always_comb begin
    rdata_d = 32'h0;
    case (type_q)
      3'd0:    rdata_d = word_rd;
      3'd1:    rdata_d = {{16{half_rd[15]}}, half_rd};
      3'd2:    rdata_d = {16'h0, half_rd};
      3'd3:    rdata_d = {{24{byte_rd[7]}}, byte_rd};
      3'd4:    rdata_d = {24'h0, byte_rd};
      default: rdata_d = 32'h0;
    endcase
    if (bad) rdata_d = 32'h0;
  end

  always_comb begin
    be      = 4'b0000;
    st_data = wdata_q;
    case (type_q)
      3'd0: be = 4'b1111;
      3'd1, 3'd2: begin
        be      = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      3'd3, 3'd4: begin
        be      = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (reset && state_q == S_ACCESS && mem_w_q && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'h0;
      mem_w_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      type_q  <= 3'h0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            mem_w_q <= mem_w;
            addr_q  <= addr;
            wdata_q <= wdata;
            type_q  <= dm_type;
            if (WAIT_CYCLES == 0) begin
              state_q <= S_ACCESS;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'h0) state_q <= S_ACCESS;
          else               cnt_q   <= cnt_q - 4'h1;
        end
        S_ACCESS: begin
          if (!mem_w_q) rdata_q <= rdata_d;
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (req) begin
            ready_q <= 1'b1;
            err_q   <= bad;
          end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed bench for data_mem_responder
// Two instances: default wait states, and WAIT_CYCLES=0 for the short-latency path.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        req, mem_w;
  logic [31:0] addr, wdata, rdata;
  logic [2:0]  dm_type;
  logic        ready, err;

  logic        req_z, mem_w_z;
  logic [31:0] addr_z, wdata_z, rdata_z;
  logic [2:0]  dm_type_z;
  logic        ready_z, err_z;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .mem_w(mem_w), .addr(addr),
    .wdata(wdata), .dm_type(dm_type), .rdata(rdata), .ready(ready), .err(err)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset), .req(req_z), .mem_w(mem_w_z), .addr(addr_z),
    .wdata(wdata_z), .dm_type(dm_type_z), .rdata(rdata_z), .ready(ready_z), .err(err_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One handshake on the default instance; inputs are scrambled right after E0.
  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] t, input int hold,
                        input logic exp_err, input logic [31:0] exp_rd);
    int lat;
    @(negedge clk);
    req = 1'b1; mem_w = w; addr = a; wdata = d; dm_type = t;
    @(posedge clk);
    @(negedge clk);
    mem_w = ~w; addr = a ^ 32'h4; wdata = ~d; dm_type = (t == 3'd0) ? 3'd4 : 3'd0;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      @(posedge clk); #1;
      if (ready === 1'b1) begin lat = k; break; end
    end
    chk({tag, ".lat"}, 32'(lat), 32'd4);
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    chk({tag, ".rdata"}, rdata, exp_rd);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_ready"}, 32'(ready), 32'd1);
    end
    @(negedge clk); req = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".ready_fall"}, 32'(ready), 32'd0);
    chk({tag, ".err_fall"}, 32'(err), 32'd0);
  endtask

  task automatic access_z(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd);
    int lat;
    @(negedge clk);
    req_z = 1'b1; mem_w_z = w; addr_z = a; wdata_z = d; dm_type_z = 3'd0;
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (ready_z === 1'b1) begin lat = k; break; end
    end
    chk({tag, ".lat"}, 32'(lat), 32'd2);
    chk({tag, ".err"}, 32'(err_z), 32'd0);
    chk({tag, ".rdata"}, rdata_z, exp_rd);
    @(negedge clk); req_z = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".ready_fall"}, 32'(ready_z), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    req = 1'b0; mem_w = 1'b0; addr = 32'h0; wdata = 32'h0; dm_type = 3'd0;
    req_z = 1'b0; mem_w_z = 1'b0; addr_z = 32'h0; wdata_z = 32'h0; dm_type_z = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", 32'(ready), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.rdata", rdata, 32'h0);
    @(negedge clk); reset = 1'b1;

    access("st_word",   1'b1, 32'h10, 32'hDEADBEEF, 3'd0, 0, 1'b0, 32'h0);
    access("ld_word",   1'b0, 32'h10, 32'h0,        3'd0, 0, 1'b0, 32'hDEADBEEF);
    access("st_byte",   1'b1, 32'h13, 32'h00000080, 3'd3, 0, 1'b0, 32'hDEADBEEF);
    access("ld_word2",  1'b0, 32'h10, 32'h0,        3'd0, 0, 1'b0, 32'h80ADBEEF);
    access("ld_bs",     1'b0, 32'h13, 32'h0,        3'd3, 0, 1'b0, 32'hFFFFFF80);
    access("ld_bu",     1'b0, 32'h13, 32'h0,        3'd4, 0, 1'b0, 32'h00000080);
    access("ld_hs",     1'b0, 32'h12, 32'h0,        3'd1, 0, 1'b0, 32'hFFFF80AD);
    access("ld_hu",     1'b0, 32'h12, 32'h0,        3'd2, 0, 1'b0, 32'h000080AD);
    access("st_mis",    1'b1, 32'h11, 32'h0,        3'd0, 0, 1'b1, 32'h000080AD);
    access("ld_after",  1'b0, 32'h10, 32'h0,        3'd0, 0, 1'b0, 32'h80ADBEEF);
    access("ld_oor",    1'b0, 32'h400, 32'h0,       3'd0, 0, 1'b1, 32'h0);
    access("ld_type",   1'b0, 32'h10, 32'h0,        3'd5, 0, 1'b1, 32'h0);
    access("ld_hmis",   1'b0, 32'h11, 32'h0,        3'd1, 0, 1'b1, 32'h0);
    access("st_1c",     1'b1, 32'h1C, 32'hCAFEF00D, 3'd0, 0, 1'b0, 32'h0);
    access("st_hold",   1'b1, 32'h18, 32'h12345678, 3'd0, 3, 1'b0, 32'h0);
    access("ld_18",     1'b0, 32'h18, 32'h0,        3'd0, 0, 1'b0, 32'h12345678);
    access("ld_1c",     1'b0, 32'h1C, 32'h0,        3'd0, 0, 1'b0, 32'hCAFEF00D);
    access("st_half",   1'b1, 32'h1E, 32'hFFFF1234, 3'd1, 0, 1'b0, 32'hCAFEF00D);
    access("ld_1c_h",   1'b0, 32'h1C, 32'h0,        3'd0, 0, 1'b0, 32'h1234F00D);
    access("st_20",     1'b1, 32'h20, 32'h11111111, 3'd0, 0, 1'b0, 32'h1234F00D);

    // Abort a store to 0x20 while it is still waiting.
    @(negedge clk);
    req = 1'b1; mem_w = 1'b1; addr = 32'h20; wdata = 32'h22222222; dm_type = 3'd0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort.ready", 32'(ready), 32'd0);
    chk("abort.err", 32'(err), 32'd0);
    chk("abort.rdata", rdata, 32'h0);
    req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    access("ld_20",     1'b0, 32'h20, 32'h0,        3'd0, 0, 1'b0, 32'h11111111);

    access_z("z_st",    1'b1, 32'h0, 32'h5A5A5A5A, 32'h0);
    access_z("z_ld",    1'b0, 32'h0, 32'h0,        32'h5A5A5A5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
